bram_in_arbiter: RTL



---
 rtl/bram_in_arbiter_pkg.sv | 21 ++
 rtl/bram_in_arbiter_rr_pick.sv | 26 ++
 rtl/bram_in_arbiter.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/bram_in_arbiter_pkg.sv
// Shared defaults, FSM state type and pointer helper for the BRAM input write arbiter.
package bram_arb_pkg;

    localparam int DEF_N_PORTS = 6;
    localparam int DEF_SEL_W   = 3;
    localparam int DEF_ADDR_W  = 10;
    localparam int DEF_LEN_W   = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    // Round-robin pointer step, wrapping at the number of sources rather than at 2^SEL_W.
    function automatic logic [DEF_SEL_W-1:0] next_ptr(input logic [DEF_SEL_W-1:0] p,
                                                      input int unsigned n);
        if (32'(p) + 32'd1 >= n) return '0;
        return p + 1'b1;
    endfunction

endpackage

// File: rtl/bram_in_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req bit at or after ptr, modulo N_PORTS.
module rr_pick
    import bram_arb_pkg::*;
#(
    parameter int N_PORTS = DEF_N_PORTS,
    parameter int SEL_W   = DEF_SEL_W
) (
    input  logic [N_PORTS-1:0] req,
    input  logic [SEL_W-1:0]   ptr,
    output logic               found,
    output logic [SEL_W-1:0]   idx
);

    // Scan from the farthest offset back to ptr so the closest requester is written last.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int k = N_PORTS - 1; k >= 0; k--) begin
            if (req[(int'(ptr) + k) % N_PORTS]) begin
                found = 1'b1;
                idx   = SEL_W'((int'(ptr) + k) % N_PORTS);
            end
        end
    end

endmodule

// File: rtl/bram_in_arbiter.sv
// Burst round-robin write arbiter for one BRAM input port; drives mux select, write enable and address.
// Optional beat-stall abort is enabled by defining BRAM_ARB_TIMEOUT_EN.
module bram_in_arbiter
    import bram_arb_pkg::*;
#(
    parameter int N_PORTS = DEF_N_PORTS,
    parameter int SEL_W   = DEF_SEL_W,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int LEN_W   = DEF_LEN_W,
    parameter int TIMEOUT = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_PORTS-1:0]        req,
    input  logic [N_PORTS*ADDR_W-1:0] req_base,
    input  logic [N_PORTS*LEN_W-1:0]  req_len,
    output logic [N_PORTS-1:0]        grant,
    input  logic [N_PORTS-1:0]        valid,
    output logic [N_PORTS-1:0]        ready,
    output logic [SEL_W-1:0]          sel,
    output logic                      bram_we,
    output logic [ADDR_W-1:0]         bram_addr,
    output logic                      busy,
    output logic                      done,
    output logic                      timeout_err
);

    if (TIMEOUT < 1) begin : g_timeout_chk
        $error("TIMEOUT must be at least 1");
    end

    state_t              state_q;
    logic [SEL_W-1:0]    ptr_q;
    logic [SEL_W-1:0]    owner_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [LEN_W-1:0]    cnt_q;
    logic [N_PORTS-1:0]  grant_q;
    logic                done_q;

    logic                pick_found;
    logic [SEL_W-1:0]    pick_idx;
    logic [ADDR_W-1:0]   base_d;
    logic [LEN_W-1:0]    len_d;
    logic [N_PORTS-1:0]  owner_oh;
    logic                beat;

    rr_pick #(
        .N_PORTS (N_PORTS),
        .SEL_W   (SEL_W)
    ) u_pick (
        .req   (req),
        .ptr   (ptr_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_comb begin
        base_d = '0;
        len_d  = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            if (pick_idx == SEL_W'(i)) begin
                base_d = req_base[i*ADDR_W +: ADDR_W];
                len_d  = req_len[i*LEN_W +: LEN_W];
            end
        end
    end

    // Data reaches the BRAM through the external mux in the same cycle, so the enable stays combinational.
    assign owner_oh  = N_PORTS'(1) << owner_q;
    assign busy      = (state_q == BURST);
    assign ready     = busy ? owner_oh : '0;
    assign beat      = |(valid & ready);
    assign bram_we   = beat;
    assign sel       = owner_q;
    assign bram_addr = addr_q;
    assign grant     = grant_q;
    assign done      = done_q;

`ifdef BRAM_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tcnt_q;
    logic          tout_q;
    assign timeout_err = tout_q;
`else
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            addr_q  <= '0;
            cnt_q   <= '0;
            grant_q <= '0;
            done_q  <= 1'b0;
`ifdef BRAM_ARB_TIMEOUT_EN
            tcnt_q  <= '0;
            tout_q  <= 1'b0;
`endif
        end else begin
            grant_q <= '0;
            done_q  <= 1'b0;
`ifdef BRAM_ARB_TIMEOUT_EN
            tout_q  <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (pick_found) begin
                        owner_q <= pick_idx;
                        addr_q  <= base_d;
                        cnt_q   <= len_d;
                        grant_q <= N_PORTS'(1) << pick_idx;
                        state_q <= BURST;
`ifdef BRAM_ARB_TIMEOUT_EN
                        tcnt_q  <= '0;
`endif
                    end
                end
                BURST: begin
                    if (beat) begin
                        addr_q <= addr_q + 1'b1;
                        cnt_q  <= cnt_q - 1'b1;
`ifdef BRAM_ARB_TIMEOUT_EN
                        tcnt_q <= '0;
`endif
                        if (cnt_q == '0) begin
                            done_q  <= 1'b1;
                            ptr_q   <= next_ptr(owner_q, N_PORTS);
                            state_q <= IDLE;
                        end
                    end
`ifdef BRAM_ARB_TIMEOUT_EN
                    // This stalled cycle is the TIMEOUT-th one in a row: abandon the burst.
                    else if (tcnt_q == TW'(TIMEOUT - 1)) begin
                        tout_q  <= 1'b1;
                        ptr_q   <= next_ptr(owner_q, N_PORTS);
                        state_q <= IDLE;
                    end else begin
                        tcnt_q <= tcnt_q + 1'b1;
                    end
`endif
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
